wb_mailbox: RTL

- Wishbone-classic responder on the Caravel management bus (wbs_* signals).
- Gives the management SoC a byte mailbox to and from the wrapped_as2650 core.
- Two 4-entry byte FIFOs:
  - down FIFO: SoC -> CPU.
  - up FIFO: CPU -> SoC.
- Also provides status/control registers and a level interrupt. Instantiated beside wrapped_as2650 inside user_project_wrapper.

---
 rtl/wb_mailbox.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_mailbox.sv
// Wishbone-classic mailbox between the management SoC and the as2650 core: two byte FIFOs,
// status/control registers and a level interrupt. Define WB_MAILBOX_OVF_EN for sticky overflow flags.
module wb_mailbox #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          DEPTH_LOG2 = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic [7:0]  cpu_rd_data,
    output logic        cpu_rd_valid,
    input  logic        cpu_rd_pop,
    input  logic [7:0]  cpu_wr_data,
    input  logic        cpu_wr_stb,
    output logic        cpu_wr_full,
    output logic        irq_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic                  ack_q, ack_d;
    logic [31:0]           dat_q, dat_d;
    logic                  ctrl_q, ctrl_d;
    logic                  irq_q, irq_d;

    logic [7:0]            dn_mem_q [DEPTH];
    logic [7:0]            dn_mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] dn_wp_q, dn_wp_d, dn_rp_q, dn_rp_d;
    logic [CW-1:0]         dn_cnt_q, dn_cnt_d;

    logic [7:0]            up_mem_q [DEPTH];
    logic [7:0]            up_mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] up_wp_q, up_wp_d, up_rp_q, up_rp_d;
    logic [CW-1:0]         up_cnt_q, up_cnt_d;

    logic                  ovf_dn, ovf_up;

    logic        addr_hit, accept, wr_en, rd_en;
    logic [1:0]  reg_idx;
    logic        dn_full, dn_empty, up_full, up_empty;
    logic        dn_push_req, dn_push, dn_pop, up_push, up_pop, flush;
    logic [31:0] rx_word, status_word, rd_mux;
    logic        unused_bits;

    // Bus handshake: a request is taken only while ack is low, so ack is a one-cycle pulse
    // and a held strobe yields at most one access every two cycles.
    assign addr_hit = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign accept   = wbs_cyc_i & wbs_stb_i & addr_hit & ~ack_q;
    assign wr_en    = accept & wbs_we_i & wbs_sel_i[0];
    assign rd_en    = accept & ~wbs_we_i;
    assign reg_idx  = wbs_adr_i[3:2];

    assign dn_full  = (dn_cnt_q == CW'(DEPTH));
    assign dn_empty = (dn_cnt_q == '0);
    assign up_full  = (up_cnt_q == CW'(DEPTH));
    assign up_empty = (up_cnt_q == '0);

    // A push into a full FIFO still lands when a pop frees the head in the same cycle.
    assign dn_pop      = cpu_rd_pop & ~dn_empty;
    assign dn_push_req = wr_en & (reg_idx == 2'd0);
    assign dn_push     = dn_push_req & (~dn_full | dn_pop);
    assign up_pop      = rd_en & wbs_sel_i[0] & (reg_idx == 2'd1) & ~up_empty;
    assign up_push     = cpu_wr_stb & (~up_full | up_pop);
    assign flush       = wr_en & (reg_idx == 2'd2) & wbs_dat_i[0];

    always_comb begin
        dn_mem_d = dn_mem_q;
        dn_wp_d  = dn_wp_q;
        dn_rp_d  = dn_rp_q;
        dn_cnt_d = dn_cnt_q;
        if (dn_push) begin
            dn_mem_d[dn_wp_q] = wbs_dat_i[7:0];
            dn_wp_d           = dn_wp_q + DEPTH_LOG2'(1);
        end
        if (dn_pop) begin
            dn_rp_d = dn_rp_q + DEPTH_LOG2'(1);
        end
        case ({dn_push, dn_pop})
            2'b10:   dn_cnt_d = dn_cnt_q + CW'(1);
            2'b01:   dn_cnt_d = dn_cnt_q - CW'(1);
            default: dn_cnt_d = dn_cnt_q;
        endcase
        if (flush) begin
            dn_wp_d  = '0;
            dn_rp_d  = '0;
            dn_cnt_d = '0;
        end
    end

    always_comb begin
        up_mem_d = up_mem_q;
        up_wp_d  = up_wp_q;
        up_rp_d  = up_rp_q;
        up_cnt_d = up_cnt_q;
        if (up_push) begin
            up_mem_d[up_wp_q] = cpu_wr_data;
            up_wp_d           = up_wp_q + DEPTH_LOG2'(1);
        end
        if (up_pop) begin
            up_rp_d = up_rp_q + DEPTH_LOG2'(1);
        end
        case ({up_push, up_pop})
            2'b10:   up_cnt_d = up_cnt_q + CW'(1);
            2'b01:   up_cnt_d = up_cnt_q - CW'(1);
            default: up_cnt_d = up_cnt_q;
        endcase
        if (flush) begin
            up_wp_d  = '0;
            up_rp_d  = '0;
            up_cnt_d = '0;
        end
    end

`ifdef WB_MAILBOX_OVF_EN
    logic ovf_dn_q, ovf_dn_d, ovf_up_q, ovf_up_d;

    // Clear-on-write-one, but a drop in the same cycle keeps the flag set.
    always_comb begin
        ovf_dn_d = ovf_dn_q;
        ovf_up_d = ovf_up_q;
        if (wr_en && (reg_idx == 2'd2) && wbs_dat_i[16]) ovf_dn_d = 1'b0;
        if (wr_en && (reg_idx == 2'd2) && wbs_dat_i[17]) ovf_up_d = 1'b0;
        if (dn_push_req && !dn_push) ovf_dn_d = 1'b1;
        if (cpu_wr_stb && !up_push)  ovf_up_d = 1'b1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            ovf_dn_q <= 1'b0;
            ovf_up_q <= 1'b0;
        end else begin
            ovf_dn_q <= ovf_dn_d;
            ovf_up_q <= ovf_up_d;
        end
    end

    assign ovf_dn = ovf_dn_q;
    assign ovf_up = ovf_up_q;
`else
    assign ovf_dn = 1'b0;
    assign ovf_up = 1'b0;
`endif

    assign rx_word     = up_empty ? 32'h0 : {23'b0, 1'b1, up_mem_q[up_rp_q]};
    assign status_word = {14'b0, ovf_up, ovf_dn, 4'b0,
                          up_empty, up_full, dn_empty, dn_full,
                          1'b0, 3'(up_cnt_q), 1'b0, 3'(dn_cnt_q)};

    always_comb begin
        case (reg_idx)
            2'd0:    rd_mux = 32'h0;
            2'd1:    rd_mux = rx_word;
            2'd2:    rd_mux = status_word;
            default: rd_mux = {31'b0, ctrl_q};
        endcase
    end

    assign ack_d  = accept;
    assign dat_d  = rd_en ? rd_mux : dat_q;
    assign ctrl_d = (wr_en && (reg_idx == 2'd3)) ? wbs_dat_i[0] : ctrl_q;
    assign irq_d  = ctrl_q & (~up_empty | ovf_dn | ovf_up);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            ctrl_q   <= 1'b0;
            irq_q    <= 1'b0;
            dn_wp_q  <= '0;
            dn_rp_q  <= '0;
            dn_cnt_q <= '0;
            up_wp_q  <= '0;
            up_rp_q  <= '0;
            up_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dn_mem_q[i] <= '0;
                up_mem_q[i] <= '0;
            end
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            ctrl_q   <= ctrl_d;
            irq_q    <= irq_d;
            dn_wp_q  <= dn_wp_d;
            dn_rp_q  <= dn_rp_d;
            dn_cnt_q <= dn_cnt_d;
            up_wp_q  <= up_wp_d;
            up_rp_q  <= up_rp_d;
            up_cnt_q <= up_cnt_d;
            dn_mem_q <= dn_mem_d;
            up_mem_q <= up_mem_d;
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign cpu_rd_data  = dn_mem_q[dn_rp_q];
    assign cpu_rd_valid = ~dn_empty;
    assign cpu_wr_full  = up_full;
    assign irq_o        = irq_q;

    assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i[31:8]};

endmodule
